// File: rtl/iob_cache_arbiter.sv
// Round-robin arbiter sharing the iob_cache native front-end port between N_MASTERS requesters.
// The winning request is registered and held until the cache answers with c_ready.
module iob_cache_arbiter #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = 30,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned GRANT_W   = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [N_MASTERS-1:0]              m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]       m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]       m_wdata,
  input  logic [N_MASTERS*(DATA_W/8)-1:0]   m_wstrb,
  output logic [DATA_W-1:0]                 m_rdata,
  output logic [N_MASTERS-1:0]              m_ready,
  output logic                              c_valid,
  output logic [ADDR_W-1:0]                 c_addr,
  output logic [DATA_W-1:0]                 c_wdata,
  output logic [(DATA_W/8)-1:0]             c_wstrb,
  input  logic [DATA_W-1:0]                 c_rdata,
  input  logic                              c_ready,
  output logic [GRANT_W-1:0]                grant,
  output logic                              busy
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_t;

  state_t             state_q;
  state_t             state_d;
  req_t               req_q;
  req_t               req_d;
  req_t               req_arr [N_MASTERS];
  logic [GRANT_W-1:0] rr_ptr;
  logic [GRANT_W-1:0] rr_ptr_d;
  logic [GRANT_W-1:0] grant_d;
  logic [GRANT_W-1:0] sel;
  logic [GRANT_W-1:0] idx;
  logic               found;
  logic               c_valid_d;
  logic               busy_d;

  // Unpack the flattened requester buses
  always_comb begin
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      req_arr[i].addr  = m_addr[i*ADDR_W +: ADDR_W];
      req_arr[i].wdata = m_wdata[i*DATA_W +: DATA_W];
      req_arr[i].wstrb = m_wstrb[i*STRB_W +: STRB_W];
    end
  end

  // First pending requester at or above rr_ptr, wrapping around
  always_comb begin
    sel   = rr_ptr;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      idx = GRANT_W'((32'(rr_ptr) + k) % N_MASTERS);
      if (!found && m_valid[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  // Next-state logic and next values of the registered request bus
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    rr_ptr_d  = rr_ptr;
    grant_d   = grant;
    c_valid_d = c_valid;
    busy_d    = busy;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d   = BUSY;
          grant_d   = sel;
          req_d     = req_arr[sel];
          c_valid_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      BUSY: begin
        if (c_ready) begin
          state_d   = IDLE;
          c_valid_d = 1'b0;
          busy_d    = 1'b0;
          rr_ptr_d  = GRANT_W'((32'(grant) + 32'd1) % N_MASTERS);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      rr_ptr  <= '0;
      grant   <= '0;
      c_valid <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rr_ptr  <= rr_ptr_d;
      grant   <= grant_d;
      c_valid <= c_valid_d;
      busy    <= busy_d;
    end
  end

  assign c_addr  = req_q.addr;
  assign c_wdata = req_q.wdata;
  assign c_wstrb = req_q.wstrb;
  assign m_rdata = c_rdata;

  // Completion pulse; a reset cycle abandons the transaction so no pulse escapes
  always_comb begin
    m_ready = '0;
    if (reset && (state_q == BUSY) && c_ready) begin
      m_ready[grant] = 1'b1;
    end
  end

endmodule
